// File: rtl/image_mem_arbiter.sv
// rtl/image_mem_arbiter.sv - shares the single-port image memory between VGA reads and loader writes
module image_mem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 24,
    parameter int MAX_WAIT = 8,
    parameter int MEM_LAT  = 1
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [15:0]       starve_cnt
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD,
        ARB_WR,
        ARB_FORCE
    } arb_state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    arb_state_t         state;
    logic [7:0]         wait_cnt;
    logic [MEM_LAT-1:0] rd_pipe;
    logic               force_wr;

    // Reads win unless the pending write has already lost MAX_WAIT cycles in a row.
    assign force_wr = wr_req && (wait_cnt == MAX_WAIT_C);
    assign wr_gnt   = wr_req && (force_wr || !rd_req);
    assign rd_gnt   = rd_req && !wr_gnt;

    assign rd_data  = mem_dout;
    assign rd_valid = rd_pipe[MEM_LAT-1];

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            mem_a      <= '0;
            mem_we     <= 1'b0;
            mem_din    <= '0;
            wait_cnt   <= 8'd0;
            starve_cnt <= 16'd0;
            rd_pipe    <= '0;
        end else begin
            if (wr_gnt) begin
                state   <= force_wr ? ARB_FORCE : ARB_WR;
                mem_a   <= wr_addr;
                mem_din <= wr_data;
                mem_we  <= 1'b1;
            end else if (rd_gnt) begin
                state  <= ARB_RD;
                mem_a  <= rd_addr;
                mem_we <= 1'b0;
            end else begin
                state  <= ARB_IDLE;
                mem_we <= 1'b0;
            end

            if (wr_req && !wr_gnt) begin
                if (wait_cnt < MAX_WAIT_C)
                    wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end

            if (force_wr && (starve_cnt != 16'hFFFF))
                starve_cnt <= starve_cnt + 16'd1;

            // ARB_RD marks the cycle the read address sits on mem_a; the pipe covers the memory latency.
            rd_pipe[0] <= (state == ARB_RD);
            for (int i = 1; i < MEM_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// tb/tb_image_mem_arbiter.sv - self-checking bench for image_mem_arbiter
module tb_image_mem_arbiter;

    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 24;
    localparam int MAX_WAIT = 8;
    localparam int MEM_LAT  = 1;

    logic              clk50;
    logic              reset;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [15:0]       starve_cnt;

    image_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk50     (clk50),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .mem_a     (mem_a),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .starve_cnt(starve_cnt)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    // Single-port synchronous pixel memory, one cycle read latency.
    logic [DATA_W-1:0] mem [512];
    always @(posedge clk50) begin
        if (mem_we)
            mem[mem_a] <= mem_din;
        mem_dout <= mem[mem_a];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [512];
    int                lost;
    int                starve;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_din;
    int                cyc;
    int                due_q [$];
    logic [DATA_W-1:0] dat_q [$];

    typedef struct {
        logic              rq;
        logic [ADDR_W-1:0] ra;
        logic              wq;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              e_rg;
        logic              e_wg;
        logic              e_v;
        logic [DATA_W-1:0] e_d;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [DATA_W-1:0] pat(input int i);
        return 24'(i * 24'h010203) ^ 24'h0F0F0F;
    endfunction

    function automatic vec_t mk(input logic rq, input logic [8:0] ra, input logic wq,
                                input logic [8:0] wa, input logic [23:0] wd, input logic e_rg,
                                input logic e_wg, input logic e_v, input logic [23:0] e_d);
        vec_t v;
        v.rq = rq; v.ra = ra; v.wq = wq; v.wa = wa; v.wd = wd;
        v.e_rg = e_rg; v.e_wg = e_wg; v.e_v = e_v; v.e_d = e_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        due_q.delete();
        dat_q.delete();
        lost    = 0;
        starve  = 0;
        exp_we  = 1'b0;
        exp_a   = '0;
        exp_din = '0;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model across the posedge.
    task automatic step(input logic rq, input logic [8:0] ra, input logic wq, input logic [8:0] wa,
                        input logic [23:0] wd, output logic g_r, output logic g_w,
                        output logic v, output logic [23:0] d);
        logic fw, ewg, erg, ev;
        rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
        @(negedge clk50);
        fw  = wq && (lost >= MAX_WAIT);
        ewg = wq && (fw || !rq);
        erg = rq && !ewg;
        g_r = rd_gnt; g_w = wr_gnt; v = rd_valid; d = rd_data;
        check("rd_gnt", 32'(g_r), 32'(erg));
        check("wr_gnt", 32'(g_w), 32'(ewg));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_a", 32'(mem_a), 32'(exp_a));
        check("mem_din", 32'(mem_din), 32'(exp_din));
        check("starve_cnt", 32'(starve_cnt), 32'(starve));
        ev = (due_q.size() > 0) && (due_q[0] == cyc);
        check("rd_valid", 32'(v), 32'(ev));
        if (ev) begin
            if (v && !$isunknown(dat_q[0]))
                check("rd_data", 32'(d), 32'(dat_q[0]));
            due_q.delete(0);
            dat_q.delete(0);
        end
        if (ewg) begin
            ref_mem[wa] = wd;
            exp_we  = 1'b1;
            exp_a   = wa;
            exp_din = wd;
            lost    = 0;
            if (fw && starve < 65535)
                starve++;
        end else begin
            exp_we = 1'b0;
            if (erg) begin
                exp_a = ra;
                due_q.push_back(cyc + 1 + MEM_LAT);
                dat_q.push_back(ref_mem[ra]);
            end
            if (!wq)
                lost = 0;
            else if (lost < MAX_WAIT)
                lost++;
        end
        @(posedge clk50);
        cyc++;
        #1;
    endtask

    function automatic logic [23:0] exp6(input int a);
        case (a)
            5:       return 24'hABCDEF;
            7:       return 24'h123456;
            10:      return 24'hC0FFEE;
            11:      return 24'h777777;
            default: return pat(a);
        endcase
    endfunction

    logic        g_r, g_w, ov;
    logic [23:0] od;
    logic        rec_v [18];
    logic [23:0] rec_d [18];
    logic        prq, pwq;
    logic [8:0]  pra, pwa;
    logic [23:0] pwd;

    initial begin
        cyc = 0;
        model_reset();
        reset = 1'b1; rd_req = 1'b1; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk50);
        check("rst_mem_a", 32'(mem_a), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_starve", 32'(starve_cnt), 32'd0);
        check("rst_rd_gnt_comb", 32'(rd_gnt), 32'd1);
        @(posedge clk50);
        #1;
        reset = 1'b0;
        // Read request still high when reset drops: granted in the first cycle after release.
        step(1'b1, 9'd0, 1'b0, 9'd0, 24'h0, g_r, g_w, ov, od);
        check("rel_first_rd_gnt", 32'(g_r), 32'd1);

        for (int i = 0; i < 512; i++)
            step(1'b0, 9'd0, 1'b1, 9'(i), pat(i), g_r, g_w, ov, od);

        tbl[0]  = mk(1'b0, 9'd0,  1'b1, 9'd5,  24'hABCDEF, 1'b0, 1'b1, 1'b0, 24'h0);
        tbl[1]  = mk(1'b1, 9'd5,  1'b0, 9'd0,  24'h0,      1'b1, 1'b0, 1'b0, 24'h0);
        tbl[2]  = mk(1'b0, 9'd0,  1'b0, 9'd0,  24'h0,      1'b0, 1'b0, 1'b0, 24'h0);
        tbl[3]  = mk(1'b0, 9'd0,  1'b0, 9'd0,  24'h0,      1'b0, 1'b0, 1'b1, 24'hABCDEF);
        tbl[4]  = mk(1'b0, 9'd0,  1'b1, 9'd7,  24'h123456, 1'b0, 1'b1, 1'b0, 24'h0);
        tbl[5]  = mk(1'b1, 9'd7,  1'b0, 9'd0,  24'h0,      1'b1, 1'b0, 1'b0, 24'h0);
        tbl[6]  = mk(1'b1, 9'd9,  1'b1, 9'd10, 24'hC0FFEE, 1'b1, 1'b0, 1'b0, 24'h0);
        tbl[7]  = mk(1'b0, 9'd0,  1'b1, 9'd10, 24'hC0FFEE, 1'b0, 1'b1, 1'b1, 24'h123456);
        tbl[8]  = mk(1'b1, 9'd10, 1'b0, 9'd0,  24'h0,      1'b1, 1'b0, 1'b1, pat(9));
        tbl[9]  = mk(1'b1, 9'd11, 1'b0, 9'd0,  24'h0,      1'b1, 1'b0, 1'b0, 24'h0);
        tbl[10] = mk(1'b0, 9'd0,  1'b1, 9'd11, 24'h777777, 1'b0, 1'b1, 1'b1, 24'hC0FFEE);
        tbl[11] = mk(1'b0, 9'd0,  1'b0, 9'd0,  24'h0,      1'b0, 1'b0, 1'b1, pat(11));
        tbl[12] = mk(1'b1, 9'd11, 1'b0, 9'd0,  24'h0,      1'b1, 1'b0, 1'b0, 24'h0);
        tbl[13] = mk(1'b0, 9'd0,  1'b0, 9'd0,  24'h0,      1'b0, 1'b0, 1'b0, 24'h0);
        tbl[14] = mk(1'b0, 9'd0,  1'b0, 9'd0,  24'h0,      1'b0, 1'b0, 1'b1, 24'h777777);
        tbl[15] = mk(1'b0, 9'd0,  1'b0, 9'd0,  24'h0,      1'b0, 1'b0, 1'b0, 24'h0);

        foreach (tbl[k]) begin
            step(tbl[k].rq, tbl[k].ra, tbl[k].wq, tbl[k].wa, tbl[k].wd, g_r, g_w, ov, od);
            check($sformatf("tbl%0d_rd_gnt", k), 32'(g_r), 32'(tbl[k].e_rg));
            check($sformatf("tbl%0d_wr_gnt", k), 32'(g_w), 32'(tbl[k].e_wg));
            check($sformatf("tbl%0d_rd_valid", k), 32'(ov), 32'(tbl[k].e_v));
            if (tbl[k].e_v)
                check($sformatf("tbl%0d_rd_data", k), 32'(od), 32'(tbl[k].e_d));
        end

        // Sixteen back-to-back reads, addresses 0..15.
        for (int i = 0; i < 18; i++) begin
            if (i < 16)
                step(1'b1, 9'(i), 1'b0, 9'd0, 24'h0, g_r, g_w, ov, od);
            else
                step(1'b0, 9'd0, 1'b0, 9'd0, 24'h0, g_r, g_w, ov, od);
            rec_v[i] = ov;
            rec_d[i] = od;
        end
        for (int i = 0; i < 18; i++) begin
            check($sformatf("t6_valid%0d", i), 32'(rec_v[i]), 32'(i >= 2));
            if (i >= 2)
                check($sformatf("t6_data%0d", i), 32'(rec_d[i]), 32'(exp6(i - 2)));
        end

        // Sustained contention: 8 reads then a forced write, repeating.
        step(1'b0, 9'd0, 1'b0, 9'd0, 24'h0, g_r, g_w, ov, od);
        for (int i = 0; i < 27; i++) begin
            step(1'b1, 9'd20, 1'b1, 9'(200 + i), 24'(i), g_r, g_w, ov, od);
            check($sformatf("t3_wr_gnt%0d", i), 32'(g_w), 32'((i % 9) == 8));
        end
        check("t3_starve", 32'(starve_cnt), 32'd3);

        // A one-cycle gap in wr_req restarts the wait count.
        step(1'b0, 9'd0, 1'b0, 9'd0, 24'h0, g_r, g_w, ov, od);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 9'd21, 1'b1, 9'd300, 24'h5A5A5A, g_r, g_w, ov, od);
            check($sformatf("t4a_wr_gnt%0d", i), 32'(g_w), 32'd0);
        end
        step(1'b1, 9'd21, 1'b0, 9'd0, 24'h0, g_r, g_w, ov, od);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 9'd22, 1'b1, 9'd301, 24'hA5A5A5, g_r, g_w, ov, od);
            check($sformatf("t4b_wr_gnt%0d", i), 32'(g_w), 32'(i == 8));
        end
        check("t4_starve", 32'(starve_cnt), 32'd4);

        // Reset one cycle after a read grant drops the in-flight read.
        step(1'b1, 9'd3, 1'b0, 9'd0, 24'h0, g_r, g_w, ov, od);
        check("t5_gnt", 32'(g_r), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_mem_a", 32'(mem_a), 32'd0);
        check("t5_mem_we", 32'(mem_we), 32'd0);
        check("t5_mem_din", 32'(mem_din), 32'd0);
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        check("t5_starve", 32'(starve_cnt), 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50);
            check($sformatf("t5_no_valid%0d", i), 32'(rd_valid), 32'd0);
        end
        @(posedge clk50);
        #1;
        reset = 1'b0;

        // Randomized traffic with held requests that are occasionally dropped.
        prq = 1'b0; pwq = 1'b0; pra = '0; pwa = '0; pwd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!prq || $urandom_range(0, 9) == 0) begin
                prq = ($urandom_range(0, 3) != 0);
                pra = 9'($urandom);
            end
            if (!pwq || $urandom_range(0, 19) == 0) begin
                pwq = ($urandom_range(0, 2) != 0);
                pwa = 9'($urandom);
                pwd = 24'($urandom);
            end
            step(prq, pra, pwq, pwa, pwd, g_r, g_w, ov, od);
            if (g_r) prq = 1'b0;
            if (g_w) pwq = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            step(1'b0, 9'd0, 1'b0, 9'd0, 24'h0, g_r, g_w, ov, od);
        check("final_queue_drained", 32'(due_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
